// File: rtl/crc_pkg.sv
// -----------------------------------------------------------------------------
// crc_pkg
// Shared definitions for the CRC frame arbiter:
//   - arb_state_t : arbiter FSM states
//   - default CRC-16 polynomial / initial value
//   - crc_next_byte(): folds one byte MSB-first into a CRC accumulator of
//     run-time-selectable width (up to CRC_MAX_W bits)
// -----------------------------------------------------------------------------
package crc_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE   = 2'd0,
    ARB_STREAM = 2'd1,
    ARB_RESULT = 2'd2
  } arb_state_t;

  localparam int          CRC_MAX_W        = 32;
  localparam logic [15:0] CRC_POLY_DEFAULT = 16'h8005;
  localparam logic [15:0] CRC_INIT_DEFAULT = 16'h0000;

  // Non-reflected, MSB-first byte update. The accumulator is carried in a
  // CRC_MAX_W-bit container; bits at or above 'width' are kept at zero so a
  // single function serves every CRC width up to CRC_MAX_W.
  function automatic logic [CRC_MAX_W-1:0] crc_next_byte(
    input logic [CRC_MAX_W-1:0] crc,
    input logic [7:0]           data,
    input logic [CRC_MAX_W-1:0] poly,
    input int                   width
  );
    logic [CRC_MAX_W-1:0] c;
    logic [CRC_MAX_W-1:0] mask;
    logic                 fb;
    for (int b = 0; b < CRC_MAX_W; b++) begin
      mask[b] = (b < width);
    end
    c = crc & mask;
    for (int i = 7; i >= 0; i--) begin
      fb = c[width-1] ^ data[i];
      c  = (c << 1) & mask;
      if (fb) begin
        c = c ^ (poly & mask);
      end
    end
    return c;
  endfunction

endpackage

// File: rtl/crc_byte_engine.sv
// -----------------------------------------------------------------------------
// crc_byte_engine
// N-bit CRC accumulator that folds one byte per enabled cycle.
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset (accumulator -> 0)
//   init        : load CRC_INIT (takes precedence over en)
//   en          : fold data[7:0] into the accumulator
//   data        : byte to fold
//   crc         : current accumulator value (registered)
// -----------------------------------------------------------------------------
module crc_byte_engine
  import crc_pkg::*;
#(
  parameter int            N        = 16,
  parameter logic [N-1:0]  CRC_POLY = N'(CRC_POLY_DEFAULT),
  parameter logic [N-1:0]  CRC_INIT = N'(CRC_INIT_DEFAULT)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         init,
  input  logic         en,
  input  logic [7:0]   data,
  output logic [N-1:0] crc
);

  logic [N-1:0]         crc_q;
  logic [N-1:0]         crc_d;
  logic [CRC_MAX_W-1:0] folded;

  always_comb begin
    folded = crc_next_byte(CRC_MAX_W'(crc_q), data, CRC_MAX_W'(CRC_POLY), N);
    crc_d  = crc_q;
    if (init) begin
      crc_d = CRC_INIT;
    end else if (en) begin
      crc_d = N'(folded);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      crc_q <= '0;
    end else begin
      crc_q <= crc_d;
    end
  end

  assign crc = crc_q;

endmodule

// File: rtl/crc_frame_arbiter.sv
// -----------------------------------------------------------------------------
// crc_frame_arbiter
// Shares one byte-wide CRC engine between NUM_REQ byte-stream requesters.
// One requester is granted per frame (round-robin); its bytes are streamed
// through the engine and, after the byte carrying s_last, the CRC, requester
// id and byte count are offered on a valid/ready result port.
// Ports:
//   clk, rst_n       : clock, asynchronous active-low reset
//   s_req[i]         : requester i has a frame pending
//   s_valid/s_last[i]: byte valid / last byte of frame for requester i
//   s_data[8i+7:8i]  : byte of requester i
//   s_ready[i]       : byte of requester i accepted when s_valid[i] & s_ready[i]
//   res_valid/ready  : result handshake
//   res_crc/id/len/ovf: CRC, granted index, saturating length, length overflow
//   busy             : arbiter not idle
// -----------------------------------------------------------------------------
module crc_frame_arbiter
  import crc_pkg::*;
#(
  parameter int            NUM_REQ  = 4,
  parameter int            N        = 16,
  parameter logic [N-1:0]  CRC_POLY = N'(CRC_POLY_DEFAULT),
  parameter logic [N-1:0]  CRC_INIT = N'(CRC_INIT_DEFAULT),
  parameter int            LEN_W    = 16,
  localparam int           ID_W     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_REQ-1:0]   s_req,
  input  logic [NUM_REQ-1:0]   s_valid,
  input  logic [NUM_REQ*8-1:0] s_data,
  input  logic [NUM_REQ-1:0]   s_last,
  output logic [NUM_REQ-1:0]   s_ready,
  output logic                 res_valid,
  input  logic                 res_ready,
  output logic [N-1:0]         res_crc,
  output logic [ID_W-1:0]      res_id,
  output logic [LEN_W-1:0]     res_len,
  output logic                 res_ovf,
  output logic                 busy
);

  arb_state_t         state_q, state_d;
  logic [ID_W-1:0]    grant_q, grant_d;
  logic [ID_W-1:0]    last_grant_q, last_grant_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic               ovf_q, ovf_d;

  logic [ID_W-1:0]    pick_idx;
  logic [ID_W-1:0]    cand;
  logic               pick_found;

  logic               g_valid;
  logic               g_last;
  logic [7:0]         g_data;

  logic               eng_init;
  logic               eng_en;
  logic [N-1:0]       eng_crc;

  // Round-robin search: first requester with s_req set, starting just after
  // the previously granted index and wrapping around. The previous winner is
  // visited last, so it cannot win twice in a row while anyone else waits.
  always_comb begin
    pick_idx   = last_grant_q;
    pick_found = 1'b0;
    cand       = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = ID_W'((int'(last_grant_q) + k) % NUM_REQ);
      if (!pick_found && s_req[cand]) begin
        pick_found = 1'b1;
        pick_idx   = cand;
      end
    end
  end

  // Only the granted lane is looked at; other lanes' traffic is ignored.
  assign g_valid = s_valid[grant_q];
  assign g_last  = s_last[grant_q];
  assign g_data  = s_data[{grant_q, 3'b000} +: 8];

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    len_d        = len_q;
    ovf_d        = ovf_q;
    eng_init     = 1'b0;
    eng_en       = 1'b0;
    case (state_q)
      ARB_IDLE: begin
        if (|s_req) begin
          grant_d  = pick_idx;
          len_d    = '0;
          ovf_d    = 1'b0;
          eng_init = 1'b1;
          state_d  = ARB_STREAM;
        end
      end
      ARB_STREAM: begin
        if (g_valid) begin
          eng_en = 1'b1;
          // Length saturates at all-ones; ovf records that it was exceeded.
          if (&len_q) begin
            ovf_d = 1'b1;
          end else begin
            len_d = len_q + LEN_W'(1);
          end
          if (g_last) begin
            state_d = ARB_RESULT;
          end
        end
      end
      ARB_RESULT: begin
        if (res_ready) begin
          last_grant_d = grant_q;
          state_d      = ARB_IDLE;
        end
      end
      default: begin
        state_d = ARB_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ARB_IDLE;
      grant_q      <= '0;
      last_grant_q <= ID_W'(NUM_REQ - 1);
      len_q        <= '0;
      ovf_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      len_q        <= len_d;
      ovf_q        <= ovf_d;
    end
  end

  crc_byte_engine #(
    .N        (N),
    .CRC_POLY (CRC_POLY),
    .CRC_INIT (CRC_INIT)
  ) u_engine (
    .clk   (clk),
    .rst_n (rst_n),
    .init  (eng_init),
    .en    (eng_en),
    .data  (g_data),
    .crc   (eng_crc)
  );

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_ready
    assign s_ready[gi] = (state_q == ARB_STREAM) && (grant_q == ID_W'(gi));
  end

  // All result fields come straight from registers that do not change while
  // in ARB_RESULT, so they are stable under backpressure.
  assign res_valid = (state_q == ARB_RESULT);
  assign res_crc   = eng_crc;
  assign res_id    = grant_q;
  assign res_len   = len_q;
  assign res_ovf   = ovf_q;
  assign busy      = (state_q != ARB_IDLE);

endmodule

// File: tb/tb_crc_frame_arbiter.sv
module tb_crc_frame_arbiter;

  localparam int NUM_REQ = 4;
  localparam int LEN_W   = 4;
  localparam int LEN_MAX = (1 << LEN_W) - 1;

  logic                 clk;
  logic                 rst_n;
  logic [NUM_REQ-1:0]   s_req;
  logic [NUM_REQ-1:0]   s_valid;
  logic [NUM_REQ*8-1:0] s_data;
  logic [NUM_REQ-1:0]   s_last;
  logic [NUM_REQ-1:0]   s_ready;
  logic                 res_valid;
  logic                 res_ready;
  logic [15:0]          res_crc;
  logic [1:0]           res_id;
  logic [LEN_W-1:0]     res_len;
  logic                 res_ovf;
  logic                 busy;

  crc_frame_arbiter #(
    .NUM_REQ  (NUM_REQ),
    .N        (16),
    .CRC_POLY (16'h8005),
    .CRC_INIT (16'h0000),
    .LEN_W    (LEN_W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .s_req     (s_req),
    .s_valid   (s_valid),
    .s_data    (s_data),
    .s_last    (s_last),
    .s_ready   (s_ready),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_crc   (res_crc),
    .res_id    (res_id),
    .res_len   (res_len),
    .res_ovf   (res_ovf),
    .busy      (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Per-requester drive lanes
  logic       req_a [NUM_REQ];
  logic       vld_a [NUM_REQ];
  logic       lst_a [NUM_REQ];
  logic [7:0] dat_a [NUM_REQ];

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      s_req[i]         = req_a[i];
      s_valid[i]       = vld_a[i];
      s_last[i]        = lst_a[i];
      s_data[8*i +: 8] = dat_a[i];
    end
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // CRC as the remainder of M(x)*x^16 mod P(x) (valid because init is 0 and
  // there is no final XOR).
  function automatic logic [15:0] ref_crc(input logic [7:0] m[$]);
    logic [16:0] r;
    r = '0;
    foreach (m[j]) begin
      for (int b = 7; b >= 0; b--) begin
        r = {r[15:0], m[j][b]};
        if (r[16]) r = r ^ 17'h18005;
      end
    end
    for (int b = 0; b < 16; b++) begin
      r = {r[15:0], 1'b0};
      if (r[16]) r = r ^ 17'h18005;
    end
    return r[15:0];
  endfunction

  function automatic int rr_pick(input logic [NUM_REQ-1:0] req, input int last);
    for (int k = 1; k <= NUM_REQ; k++) begin
      if (req[(last + k) % NUM_REQ]) return (last + k) % NUM_REQ;
    end
    return -1;
  endfunction

  // Frames completed by the drivers, per requester, in order.
  logic [15:0] exp_crc [NUM_REQ][$];
  int          exp_cnt [NUM_REQ][$];

  int  phase   = 0;          // 0 idle, 1 streaming, 2 result offered
  int  cur_g   = 0;
  int  last_id = NUM_REQ - 1;
  int  n_results = 0;
  int  id_log[$];
  logic [15:0] last_crc;
  int  last_len;
  int  last_ovf;
  int  last_rid;

  function automatic int pending_total();
    int t = 0;
    for (int i = 0; i < NUM_REQ; i++) t += exp_crc[i].size();
    return t;
  endfunction

  always @(negedge clk) begin
    if (!rst_n) begin
      chk("rst_s_ready", 32'(s_ready), 0);
      chk("rst_res_valid", 32'(res_valid), 0);
      chk("rst_res_crc", 32'(res_crc), 0);
      chk("rst_res_id", 32'(res_id), 0);
      chk("rst_res_len", 32'(res_len), 0);
      chk("rst_res_ovf", 32'(res_ovf), 0);
      chk("rst_busy", 32'(busy), 0);
      phase   = 0;
      last_id = NUM_REQ - 1;
      for (int i = 0; i < NUM_REQ; i++) begin
        exp_crc[i].delete();
        exp_cnt[i].delete();
      end
    end else begin
      case (phase)
        0: begin
          chk("idle_s_ready", 32'(s_ready), 0);
          chk("idle_res_valid", 32'(res_valid), 0);
          chk("idle_busy", 32'(busy), 0);
          if (s_req != 0) begin
            cur_g = rr_pick(s_req, last_id);
            phase = 1;
          end
        end
        1: begin
          chk("stream_s_ready", 32'(s_ready), 32'(1) << cur_g);
          chk("stream_res_valid", 32'(res_valid), 0);
          chk("stream_busy", 32'(busy), 1);
          if (s_valid[cur_g] && s_last[cur_g]) phase = 2;
        end
        default: begin
          chk("result_s_ready", 32'(s_ready), 0);
          chk("result_res_valid", 32'(res_valid), 1);
          chk("result_busy", 32'(busy), 1);
          if (exp_crc[cur_g].size() == 0) begin
            checks++;
            errors++;
            $display("FAIL result_unexpected: res_id=%0d but no completed frame from requester %0d", res_id, cur_g);
          end else begin
            chk("res_id", 32'(res_id), 32'(cur_g));
            chk("res_crc", 32'(res_crc), 32'(exp_crc[cur_g][0]));
            chk("res_len", 32'(res_len),
                32'((exp_cnt[cur_g][0] > LEN_MAX) ? LEN_MAX : exp_cnt[cur_g][0]));
            chk("res_ovf", 32'(res_ovf), 32'(exp_cnt[cur_g][0] > LEN_MAX));
          end
          if (res_ready) begin
            last_crc = res_crc;
            last_len = int'(res_len);
            last_ovf = int'(res_ovf);
            last_rid = int'(res_id);
            id_log.push_back(int'(res_id));
            n_results++;
            if (exp_crc[cur_g].size() != 0) begin
              void'(exp_crc[cur_g].pop_front());
              void'(exp_cnt[cur_g].pop_front());
            end
            last_id = cur_g;
            phase   = 0;
          end
        end
      endcase
    end
  end

  // ---------------- result consumer ----------------
  int ready_mode = 0;   // 0 always ready, 1 random, 2 stalled
  initial begin
    res_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0:       res_ready = 1'b1;
        1:       res_ready = 1'($urandom_range(0, 1));
        default: res_ready = 1'b0;
      endcase
    end
  end

  // Requester 1 babbling without a request.
  bit foreign_on = 0;
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (foreign_on) begin
        vld_a[1] = 1'b1;
        dat_a[1] = 8'($urandom);
        lst_a[1] = 1'($urandom);
      end
    end
  end

  // ---------------- drivers ----------------
  // Called just after a rising edge. stop_after>0 abandons the frame once
  // that many bytes have been accepted (inputs left as they were).
  task automatic send_frame(input int i, input int len, input bit golden,
                            input int bubble_pct, input bit keep_req,
                            input bit drop_mid, input int stop_after);
    logic [7:0] msg[$];
    int k = 0;
    int guard = 0;
    bit acc;
    for (int j = 0; j < len; j++) msg.push_back(golden ? 8'(8'h31 + j) : 8'($urandom));
    req_a[i] = 1'b1;
    while (k < len && guard < 2000) begin
      if (int'($urandom_range(0, 99)) < bubble_pct) begin
        vld_a[i] = 1'b0;
        dat_a[i] = 8'($urandom);
        lst_a[i] = 1'($urandom);
      end else begin
        vld_a[i] = 1'b1;
        dat_a[i] = msg[k];
        lst_a[i] = (k == len - 1);
      end
      @(negedge clk);
      acc = vld_a[i] && s_ready[i];
      @(posedge clk);
      #1;
      guard++;
      if (acc) begin
        k++;
        if (drop_mid && k == 1 && len > 1) req_a[i] = 1'b0;
        if (stop_after > 0 && k == stop_after) return;
      end
    end
    vld_a[i] = 1'b0;
    lst_a[i] = 1'b0;
    if (!keep_req) req_a[i] = 1'b0;
    if (k < len) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: requester %0d sent %0d of %0d bytes", i, k, len);
    end else begin
      exp_crc[i].push_back(ref_crc(msg));
      exp_cnt[i].push_back(len);
    end
  endtask

  task automatic rand_stream(input int r, input int nf);
    for (int f = 0; f < nf; f++) begin
      send_frame(r, int'($urandom_range(1, 20)), 0, 30,
                 (f < nf - 1) && 1'($urandom), 1'($urandom), 0);
      repeat (int'($urandom_range(0, 3))) @(posedge clk);
      #1;
    end
  endtask

  task automatic drain();
    int n = 0;
    while ((pending_total() != 0 || phase != 0) && n < 500) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk);
    #1;
    checks++;
    if (pending_total() != 0 || phase != 0) begin
      errors++;
      $display("FAIL drain_timeout: %0d results still outstanding, phase %0d", pending_total(), phase);
    end
  endtask

  task automatic clear_lanes();
    for (int i = 0; i < NUM_REQ; i++) begin
      req_a[i] = 1'b0;
      vld_a[i] = 1'b0;
      lst_a[i] = 1'b0;
      dat_a[i] = 8'h00;
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    clear_lanes();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  int base;

  initial begin
    clear_lanes();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Golden frame
    send_frame(0, 9, 1, 0, 0, 0, 0);
    drain();
    chk("golden_crc", 32'(last_crc), 32'h0000FEE8);
    chk("golden_len", 32'(last_len), 9);
    chk("golden_id", 32'(last_rid), 0);
    chk("golden_ovf", 32'(last_ovf), 0);
    $display("golden: crc=%h len=%0d id=%0d", last_crc, last_len, last_rid);

    // Round-robin with all requests held
    do_reset();
    id_log.delete();
    fork
      begin send_frame(0, 1, 0, 0, 1, 0, 0); send_frame(0, 1, 0, 0, 0, 0, 0); end
      begin send_frame(1, 1, 0, 0, 1, 0, 0); send_frame(1, 1, 0, 0, 0, 0, 0); end
      begin send_frame(2, 1, 0, 0, 1, 0, 0); send_frame(2, 1, 0, 0, 0, 0, 0); end
      begin send_frame(3, 1, 0, 0, 1, 0, 0); send_frame(3, 1, 0, 0, 0, 0, 0); end
    join
    drain();
    chk("rr_count", 32'(id_log.size()), 8);
    if (id_log.size() >= 5) begin
      chk("rr_id0", 32'(id_log[0]), 0);
      chk("rr_id1", 32'(id_log[1]), 1);
      chk("rr_id2", 32'(id_log[2]), 2);
      chk("rr_id3", 32'(id_log[3]), 3);
      chk("rr_id4", 32'(id_log[4]), 0);
    end
    $display("round-robin: %0d results", id_log.size());

    // Result backpressure; requester 1 waits with a pending request
    ready_mode = 2;
    send_frame(0, 9, 1, 0, 0, 0, 0);
    req_a[1] = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("bp_res_valid", 32'(res_valid), 1);
      chk("bp_res_crc", 32'(res_crc), 32'h0000FEE8);
      chk("bp_res_len", 32'(res_len), 9);
      chk("bp_s_ready", 32'(s_ready), 0);
    end
    @(posedge clk);
    #1;
    ready_mode = 0;
    send_frame(1, 3, 0, 0, 0, 0, 0);
    drain();
    chk("bp_next_id", 32'(last_rid), 1);
    $display("backpressure: next grant id=%0d", last_rid);

    // Bubbles on requester 2, garbage on requester 1 without request
    foreign_on = 1;
    send_frame(2, 9, 1, 50, 0, 0, 0);
    drain();
    foreign_on = 0;
    @(posedge clk);
    #1;
    vld_a[1] = 1'b0;
    lst_a[1] = 1'b0;
    chk("bubble_crc", 32'(last_crc), 32'h0000FEE8);
    chk("bubble_id", 32'(last_rid), 2);
    $display("bubbles: crc=%h id=%0d", last_crc, last_rid);

    // Length saturation boundaries
    send_frame(3, 15, 0, 0, 0, 0, 0);
    drain();
    chk("len15_len", 32'(last_len), 15);
    chk("len15_ovf", 32'(last_ovf), 0);
    send_frame(3, 16, 0, 0, 0, 0, 0);
    drain();
    chk("len16_len", 32'(last_len), 15);
    chk("len16_ovf", 32'(last_ovf), 1);
    send_frame(3, 20, 0, 0, 0, 0, 0);
    drain();
    chk("len20_len", 32'(last_len), 15);
    chk("len20_ovf", 32'(last_ovf), 1);
    $display("overflow: len=%0d ovf=%0d", last_len, last_ovf);

    // Reset in the middle of a frame
    base = n_results;
    send_frame(0, 9, 1, 0, 0, 0, 4);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_s_ready", 32'(s_ready), 0);
    chk("midrst_busy", 32'(busy), 0);
    chk("midrst_res_valid", 32'(res_valid), 0);
    chk("midrst_res_len", 32'(res_len), 0);
    chk("midrst_res_crc", 32'(res_crc), 0);
    clear_lanes();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    chk("midrst_no_result", 32'(n_results), 32'(base));
    send_frame(0, 9, 1, 0, 0, 0, 0);
    drain();
    chk("midrst_golden_crc", 32'(last_crc), 32'h0000FEE8);
    chk("midrst_golden_id", 32'(last_rid), 0);
    $display("reset mid-frame: results after=%0d crc=%h", n_results - base, last_crc);

    // Randomized contention with random consumer backpressure
    ready_mode = 1;
    base = n_results;
    fork
      rand_stream(0, 4);
      rand_stream(1, 4);
      rand_stream(2, 4);
      rand_stream(3, 4);
    join
    drain();
    ready_mode = 0;
    chk("random_results", 32'(n_results - base), 16);
    $display("random: %0d results", n_results - base);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
